// File: rtl/fastclkdiv_reload.sv
// fastclkdiv_reload: reloadable down-counter clock divider.
// The counter is split into NBITS_STAGE-wide segments. Each segment keeps a
// registered zero flag, so a segment's borrow-in depends only on the flags of
// the segments below it and not on a full-width compare. Flags are recomputed
// in the same edge as the count on load, decrement and reload, which keeps
// o_q and o_zero exact on every cycle.
module fastclkdiv_reload #(
  parameter int NBITS       = 16,
  parameter int NBITS_STAGE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_load_q,
  input  logic             i_periodic,
  output logic [NBITS-1:0] o_q,
  output logic             o_zero,
  output logic             o_tick
);

  localparam int NSTAGES = (NBITS + NBITS_STAGE - 1) / NBITS_STAGE;

  typedef enum logic {
    ARM_OFF = 1'b0,
    ARM_ON  = 1'b1
  } arm_t;

  arm_t               arm_state;
  arm_t               arm_next;
  logic [NBITS-1:0]   cnt;
  logic [NBITS-1:0]   reload;
  logic [NSTAGES-1:0] zf;
  logic [NSTAGES-1:0] rzf;
  logic               tick;
  logic               event_e;
  logic               do_dec;
  logic               do_reload;

  assign o_q    = cnt;
  assign o_zero = &zf;
  assign o_tick = tick;

  // Terminal-count event, action selects and next arm state.
  always_comb begin
    event_e   = i_en & o_zero & (arm_state == ARM_ON) & ~i_load;
    do_dec    = ~i_load & i_en & ~o_zero;
    do_reload = event_e & i_periodic;
    arm_next  = arm_state;
    if (i_load) begin
      arm_next = ARM_ON;
    end else if (event_e && !i_periodic) begin
      arm_next = ARM_OFF;
    end
  end

  // Arm state register: disarmed after reset or a one-shot terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      arm_state <= ARM_OFF;
    end else begin
      arm_state <= arm_next;
    end
  end

  // Reload value register, written only by a load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reload <= '0;
    end else if (i_load) begin
      reload <= i_load_q;
    end
  end

  // Registered single-cycle tick; event_e already excludes load cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick <= 1'b0;
    end else begin
      tick <= event_e;
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int          LO = k * NBITS_STAGE;
    localparam int          W  = ((NBITS - LO) < NBITS_STAGE) ? (NBITS - LO) : NBITS_STAGE;
    localparam int unsigned K  = k;

    logic [W-1:0] seg;
    logic [W-1:0] r_seg;
    logic         z_r;
    logic         rz_r;
    logic         lower_zero;

    assign r_seg        = reload[LO +: W];
    assign cnt[LO +: W] = seg;
    assign zf[k]        = z_r;
    assign rzf[k]       = rz_r;

    // Borrow-in: every lower segment is currently zero.
    always_comb begin
      lower_zero = 1'b1;
      for (int unsigned j = 0; j < NSTAGES; j++) begin
        if (j < K) begin
          lower_zero = lower_zero & zf[j];
        end
      end
    end

    // Segment count and its zero flag; a segment reaching zero on decrement
    // is detected from its current value being one, so no compare follows
    // the subtractor.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        seg  <= '0;
        z_r  <= 1'b1;
        rz_r <= 1'b1;
      end else if (i_load) begin
        seg  <= i_load_q[LO +: W];
        z_r  <= (i_load_q[LO +: W] == '0);
        rz_r <= (i_load_q[LO +: W] == '0);
      end else if (do_dec) begin
        if (lower_zero) begin
          seg <= seg - W'(1);
          z_r <= (seg == W'(1));
        end
      end else if (do_reload) begin
        seg <= r_seg;
        z_r <= rz_r;
      end
    end
  end

endmodule

// File: tb/tb_fastclkdiv_reload.sv
// Testbench for fastclkdiv_reload: directed scenarios with closed-form
// expectations plus randomized stimulus against a behavioural model.
module tb_fastclkdiv_reload;

  localparam int NB = 9;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic          periodic = 1'b0;
  logic [NB-1:0] load_q = '0;
  logic [NB-1:0] q;
  logic          zero;
  logic          tick;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_cnt = 0;
  int m_r   = 0;
  bit m_arm = 1'b0;
  bit m_tick = 1'b0;

  fastclkdiv_reload #(.NBITS(NB), .NBITS_STAGE(NS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_load     (load),
    .i_load_q   (load_q),
    .i_periodic (periodic),
    .o_q        (q),
    .o_zero     (zero),
    .o_tick     (tick)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance one edge, update the model.
  task automatic cycle(input bit r, input bit e, input bit l, input bit p, input int v);
    bit ev;
    rst      = r;
    en       = e;
    load     = l;
    periodic = p;
    load_q   = NB'(v);
    ev = e && !l && (m_cnt == 0) && m_arm;
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = 0; m_r = 0; m_arm = 0; m_tick = 0;
    end else if (l) begin
      m_cnt = v; m_r = v; m_arm = 1; m_tick = 0;
    end else begin
      m_tick = ev;
      if (e && m_cnt != 0) m_cnt = m_cnt - 1;
      else if (ev && p) m_cnt = m_r;
      else if (ev) m_arm = 0;
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 77);
    checks++;
    if (q !== 9'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %0b expected 1", zero); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", tick); end
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 0, 1, 0);
      checks++;
      if (q !== 9'd0 || zero !== 1'b1) begin
        errors++; $display("FAIL idle_q k=%0d: got q=%0d zero=%0b expected q=0 zero=1", k, q, zero);
      end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL idle_tick k=%0d: got %0b expected 0", k, tick); end
    end
  endtask

  task automatic test_periodic();
    int exp_q;
    bit exp_t;
    cycle(0, 1, 1, 1, 100);
    checks++;
    if (q !== 9'd100) begin errors++; $display("FAIL per_load_q: got %0d expected 100", q); end
    for (int k = 1; k <= 303; k++) begin
      cycle(0, 1, 0, 1, 0);
      exp_q = (((100 - k) % 101) + 101) % 101;
      exp_t = (k % 101 == 0);
      checks++;
      if (int'(q) != exp_q) begin errors++; $display("FAIL per_q k=%0d: got %0d expected %0d", k, q, exp_q); end
      checks++;
      if (zero !== (exp_q == 0)) begin errors++; $display("FAIL per_zero k=%0d: got %0b expected %0b", k, zero, exp_q == 0); end
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL per_tick k=%0d: got %0b expected %0b", k, tick, exp_t); end
    end
  endtask

  task automatic test_oneshot();
    int exp_q;
    for (int pass = 0; pass < 2; pass++) begin
      cycle(0, 1, 1, 0, 5);
      for (int k = 1; k <= 36; k++) begin
        cycle(0, 1, 0, 0, 0);
        exp_q = (k <= 5) ? 5 - k : 0;
        checks++;
        if (int'(q) != exp_q) begin errors++; $display("FAIL os_q p=%0d k=%0d: got %0d expected %0d", pass, k, q, exp_q); end
        checks++;
        if (tick !== (k == 6)) begin errors++; $display("FAIL os_tick p=%0d k=%0d: got %0b expected %0b", pass, k, tick, k == 6); end
      end
    end
  endtask

  task automatic test_short_periods();
    logic [NB-1:0] frozen;
    cycle(0, 1, 1, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 1, 0, 1, 0);
      checks++;
      if (tick !== (k % 2 == 0) || int'(q) != ((k % 2 == 0) ? 1 : 0)) begin
        errors++; $display("FAIL p1 k=%0d: got q=%0d tick=%0b expected q=%0d tick=%0b", k, q, tick, (k % 2 == 0) ? 1 : 0, k % 2 == 0);
      end
    end
    cycle(0, 1, 1, 1, 0);
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL p0_load_tick: got %0b expected 0", tick); end
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 1, 0, 1, 0);
      checks++;
      if (tick !== 1'b1 || q !== 9'd0) begin
        errors++; $display("FAIL p0 k=%0d: got q=%0d tick=%0b expected q=0 tick=1", k, q, tick);
      end
    end
    cycle(0, 1, 1, 1, 7);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, 0);
    frozen = q;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (q !== frozen || tick !== 1'b0) begin
        errors++; $display("FAIL freeze k=%0d: got q=%0d tick=%0b expected q=%0d tick=0", k, q, tick, frozen);
      end
    end
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 0, 1, 0);
      checks++;
      if (int'(q) != m_cnt || tick !== m_tick) begin
        errors++; $display("FAIL resume k=%0d: got q=%0d tick=%0b expected q=%0d tick=%0b", k, q, tick, m_cnt, m_tick);
      end
    end
  endtask

  task automatic test_load_collide();
    int guard;
    cycle(0, 1, 1, 1, 3);
    guard = 0;
    while (!(m_cnt == 0 && m_arm) && guard < 20) begin
      cycle(0, 1, 0, 1, 0);
      guard++;
    end
    checks++;
    if (guard >= 20) begin errors++; $display("FAIL collide_setup: got timeout expected zero within 20"); end
    cycle(0, 1, 1, 1, 200);
    checks++;
    if (tick !== 1'b0 || q !== 9'd200) begin
      errors++; $display("FAIL collide: got q=%0d tick=%0b expected q=200 tick=0", q, tick);
    end
    cycle(0, 1, 0, 1, 0);
    checks++;
    if (tick !== 1'b0 || q !== 9'd199) begin
      errors++; $display("FAIL collide_next: got q=%0d tick=%0b expected q=199 tick=0", q, tick);
    end
    cycle(0, 1, 1, 1, 50);
    for (int k = 0; k < 13; k++) cycle(0, 1, 0, 1, 0);
    checks++;
    if (q !== 9'd37) begin errors++; $display("FAIL pre_rst_q: got %0d expected 37", q); end
    cycle(1, 1, 0, 1, 0);
    checks++;
    if (q !== 9'd0 || tick !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got q=%0d tick=%0b expected q=0 tick=0", q, tick);
    end
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 0, 1, 0);
      checks++;
      if (q !== 9'd0 || tick !== 1'b0) begin
        errors++; $display("FAIL post_rst k=%0d: got q=%0d tick=%0b expected q=0 tick=0", k, q, tick);
      end
    end
  endtask

  task automatic test_random();
    bit r, e, l, p;
    int v;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom % 200) == 0;
      l = ($urandom % 16) == 0;
      e = ($urandom % 8) != 0;
      p = ($urandom % 4) != 0;
      v = (($urandom % 4) == 0) ? int'($urandom % 512) : int'($urandom % 6);
      cycle(r, e, l, p, v);
      checks++;
      if (int'(q) != m_cnt) begin errors++; $display("FAIL rnd_q k=%0d: got %0d expected %0d", k, q, m_cnt); end
      checks++;
      if (zero !== (m_cnt == 0)) begin errors++; $display("FAIL rnd_zero k=%0d: got %0b expected %0b", k, zero, m_cnt == 0); end
      checks++;
      if (tick !== m_tick) begin errors++; $display("FAIL rnd_tick k=%0d: got %0b expected %0b", k, tick, m_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_short_periods();
    test_load_collide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
